// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressed data memory.
//   dmem_size_e : core access size encoding (2'b11 is reserved and decoded as a word).
//   DEPTH()     : number of bytes for a given byte-address width.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } dmem_size_e;

   function automatic int unsigned DEPTH(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/dmem_loader.sv
// Sequential byte loader: owns the fill pointer and the sticky full flag.
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   load_i       : loader strobe
//   load_we_o    : write enable for mem[load_ptr_o] this cycle
//   load_ptr_o   : next byte address to be filled
//   load_full_o  : set once every byte has been filled, cleared only by reset
module dmem_loader #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   output logic              load_we_o,
   output logic [ADDR_W-1:0] load_ptr_o,
   output logic              load_full_o
);

   logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
   logic              load_full_q, load_full_d;
   logic              load_accept;

   always_comb begin
      load_accept = load_i & ~load_full_q;
      load_ptr_d  = load_ptr_q;
      load_full_d = load_full_q;
      if (load_accept) begin
         load_ptr_d = load_ptr_q + ADDR_W'(1);
         // Filling the top byte wraps the pointer and marks the array full.
         if (&load_ptr_q) begin
            load_full_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_ptr_q  <= '0;
         load_full_q <= 1'b0;
      end else begin
         load_ptr_q  <= load_ptr_d;
         load_full_q <= load_full_d;
      end
   end

   // Reset wins over a coincident strobe, so nothing is written in a reset cycle.
   assign load_we_o   = rst_n & load_accept;
   assign load_ptr_o  = load_ptr_q;
   assign load_full_o = load_full_q;

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressed little-endian data memory with a sequential loader port and a
// core port supporting byte/half/word loads and stores.
// Ports:
//   clk, rst_n              : clock and synchronous active-low reset
//   load, store             : loader strobe and byte (fills from address 0 upward)
//   ready                   : core-ready; low stalls core accesses
//   mem_write, mem_read     : core requests (write wins when both are high)
//   size, unsigned_ld       : access size and zero/sign extension select for loads
//   address, write_data     : core byte address (wraps modulo depth) and store data
//   read_data, read_valid   : registered load result and its one-cycle valid pulse
//   load_full               : sticky flag, loader has filled every byte
//   misaligned              : one-cycle pulse for a trapped misaligned access
// Build option DMEM_MISALIGN_TRAP_EN: when defined, misaligned accesses are suppressed
// and flagged; otherwise they are forced down to the size boundary and performed.
module byte_data_memory
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LOAD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LOAD_W-1:0] store,
   input  logic              ready,
   input  logic              mem_write,
   input  logic              mem_read,
   input  logic [1:0]        size,
   input  logic              unsigned_ld,
   input  logic [31:0]       address,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   output logic              read_valid,
   output logic              load_full,
   output logic              misaligned
);

   localparam int unsigned Depth = DEPTH(ADDR_W);

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam logic TrapEn = 1'b1;
`else
   localparam logic TrapEn = 1'b0;
`endif

   logic [7:0]        mem_q [Depth];

   logic [ADDR_W-1:0] addr, base;
   logic [3:0]        byte_en;
   logic              is_misaligned, core_access, trap, do_write, do_read, ext;
   logic [ADDR_W-1:0] lane_addr [4];
   logic [7:0]        lane_wdata [4];
   logic [3:0]        lane_we;
   logic [7:0]        rd_byte [4];
   logic [31:0]       load_value;

   logic [31:0]       read_data_q, read_data_d;
   logic              read_valid_q, read_valid_d;
   logic              misaligned_q, misaligned_d;

   logic              loader_we;
   logic [ADDR_W-1:0] load_ptr;

   logic              unused_addr;
   assign unused_addr = ^address[31:ADDR_W];

   dmem_loader #(
      .ADDR_W (ADDR_W)
   ) u_loader (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load),
      .load_we_o   (loader_we),
      .load_ptr_o  (load_ptr),
      .load_full_o (load_full)
   );

   always_comb begin
      addr = address[ADDR_W-1:0];
      case (dmem_size_e'(size))
         SZ_BYTE: begin
            byte_en       = 4'b0001;
            is_misaligned = 1'b0;
            base          = addr;
         end
         SZ_HALF: begin
            byte_en       = 4'b0011;
            is_misaligned = addr[0];
            base          = {addr[ADDR_W-1:1], 1'b0};
         end
         default: begin
            byte_en       = 4'b1111;
            is_misaligned = |addr[1:0];
            base          = {addr[ADDR_W-1:2], 2'b00};
         end
      endcase

      // Loader owns the cycle; otherwise a stall blocks any core access.
      core_access = ~load & ready & (mem_write | mem_read);
      trap        = TrapEn & is_misaligned;
      do_write    = rst_n & core_access & mem_write & ~trap;
      do_read     = core_access & ~mem_write & mem_read & ~trap;

      for (int i = 0; i < 4; i++) begin
         lane_addr[i]  = base + ADDR_W'(i);
         rd_byte[i]    = mem_q[lane_addr[i]];
         lane_wdata[i] = write_data[8*i +: 8];
         lane_we[i]    = do_write & byte_en[i];
      end

      // Loader and core writes are mutually exclusive, so lane 0 is shared.
      if (loader_we) begin
         lane_addr[0]  = load_ptr;
         lane_wdata[0] = store;
         lane_we[0]    = 1'b1;
      end

      ext = ~unsigned_ld;
      case (dmem_size_e'(size))
         SZ_BYTE: begin
            ext        = ext & rd_byte[0][7];
            load_value = {{24{ext}}, rd_byte[0]};
         end
         SZ_HALF: begin
            ext        = ext & rd_byte[1][7];
            load_value = {{16{ext}}, rd_byte[1], rd_byte[0]};
         end
         default: begin
            load_value = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
         end
      endcase

      read_data_d  = do_read ? load_value : read_data_q;
      read_valid_d = do_read;
      misaligned_d = TrapEn & core_access & is_misaligned;
   end

   // Contents are deliberately left untouched by reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (lane_we[i]) begin
            mem_q[lane_addr[i]] <= lane_wdata[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign read_data  = read_data_q;
   assign read_valid = read_valid_q;
   assign misaligned = misaligned_q;

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory: directed scenarios plus randomized core
// traffic compared against a byte-array reference model.
module tb_byte_data_memory;

   localparam int unsigned AddrW = 10;
   localparam int unsigned Depth = 1024;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [7:0]  store = '0;
   logic        ready = 1'b0;
   logic        mem_write = 1'b0;
   logic        mem_read = 1'b0;
   logic [1:0]  size = '0;
   logic        unsigned_ld = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        read_valid;
   logic        load_full;
   logic        misaligned;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [7:0]  model_mem [Depth];
   int unsigned model_ptr = 0;
   bit          model_full = 1'b0;
   logic [31:0] exp_rd_data = '0;

   always #5 clk = ~clk;

   byte_data_memory #(
      .ADDR_W (AddrW),
      .LOAD_W (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .store       (store),
      .ready       (ready),
      .mem_write   (mem_write),
      .mem_read    (mem_read),
      .size        (size),
      .unsigned_ld (unsigned_ld),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .read_valid  (read_valid),
      .load_full   (load_full),
      .misaligned  (misaligned)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic load_during);
      rst_n     = 1'b0;
      load      = load_during;
      store     = 8'hEE;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      step();
      rst_n       = 1'b1;
      load        = 1'b0;
      model_ptr   = 0;
      model_full  = 1'b0;
      exp_rd_data = '0;
      check_eq("rst/read_data", read_data, 32'h0);
      check_eq("rst/read_valid", {31'b0, read_valid}, 32'h0);
      check_eq("rst/load_full", {31'b0, load_full}, 32'h0);
      check_eq("rst/misaligned", {31'b0, misaligned}, 32'h0);
   endtask

   // A core read is held high alongside the strobe to exercise loader priority.
   task automatic load_byte(input logic [7:0] b);
      load      = 1'b1;
      store     = b;
      ready     = 1'b1;
      mem_read  = 1'b1;
      mem_write = 1'b0;
      step();
      load     = 1'b0;
      mem_read = 1'b0;
      if (!model_full) begin
         model_mem[model_ptr] = b;
         model_ptr++;
         if (model_ptr == Depth) begin
            model_ptr  = 0;
            model_full = 1'b1;
         end
      end
      check_eq("load/load_full", {31'b0, load_full}, {31'b0, model_full});
      check_eq("load/read_valid", {31'b0, read_valid}, 32'h0);
      check_eq("load/read_data", read_data, exp_rd_data);
   endtask

   task automatic core_op(input string tag, input logic wr, input logic rd,
                          input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic uns, input logic rdy);
      int unsigned nb, a, base;
      longint      v;
      bit          exp_valid, exp_mis;
      load        = 1'b0;
      mem_write   = wr;
      mem_read    = rd;
      size        = sz;
      address     = addr;
      write_data  = wdata;
      unsigned_ld = uns;
      ready       = rdy;
      step();
      nb        = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a         = addr % Depth;
      exp_valid = 1'b0;
      exp_mis   = 1'b0;
      if (rdy && (wr || rd)) begin
         if ((a % nb) != 0 && TrapEn) begin
            exp_mis = 1'b1;
         end else begin
            base = a - (a % nb);
            if (wr) begin
               for (int i = 0; i < nb; i++) begin
                  model_mem[(base + i) % Depth] = 8'((wdata >> (8 * i)) & 32'hFF);
               end
            end else begin
               v = 0;
               for (int i = 0; i < nb; i++) begin
                  v += longint'(model_mem[(base + i) % Depth]) << (8 * i);
               end
               if (!uns && nb < 4 && v >= (64'sd1 <<< (8 * nb - 1))) begin
                  v -= (64'sd1 <<< (8 * nb));
               end
               exp_rd_data = v[31:0];
               exp_valid   = 1'b1;
            end
         end
      end
      check_eq({tag, "/read_valid"}, {31'b0, read_valid}, {31'b0, exp_valid});
      check_eq({tag, "/read_data"}, read_data, exp_rd_data);
      check_eq({tag, "/misaligned"}, {31'b0, misaligned}, {31'b0, exp_mis});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] r_addr;
      do_reset(1'b0);

      // Four loaded bytes read back as one little-endian word.
      load_byte(8'h11);
      load_byte(8'h22);
      load_byte(8'h33);
      load_byte(8'h44);
      core_op("rd_w0", 1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 1'b0, 1'b1);
      check_eq("load_word", read_data, 32'h4433_2211);
      core_op("idle", 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);

      // Fill the rest of the array, then confirm the overflow strobe is ignored.
      for (int i = 4; i < Depth; i++) begin
         load_byte(8'($urandom));
      end
      check_eq("full_set", {31'b0, load_full}, 32'h1);
      load_byte(8'h5A);
      core_op("rd_b0", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
      check_eq("no_overwrite", read_data, 32'h0000_0011);

      // Reset clears the flag; a strobe coincident with reset stores nothing.
      do_reset(1'b0);
      do_reset(1'b1);
      load_byte(8'hA5);
      core_op("rd_b0r", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
      check_eq("reload_addr0", read_data, 32'h0000_00A5);
      core_op("rd_b1r", 1'b0, 1'b1, 2'd0, 32'h1, 32'h0, 1'b1, 1'b1);
      check_eq("keep_addr1", read_data, 32'h0000_0022);

      // Byte sign/zero extension.
      core_op("wr_b5", 1'b1, 1'b0, 2'd0, 32'h5, 32'h0000_0080, 1'b0, 1'b1);
      core_op("rd_b5s", 1'b0, 1'b1, 2'd0, 32'h5, 32'h0, 1'b0, 1'b1);
      check_eq("byte_signed", read_data, 32'hFFFF_FF80);
      core_op("rd_b5u", 1'b0, 1'b1, 2'd0, 32'h5, 32'h0, 1'b1, 1'b1);
      check_eq("byte_unsigned", read_data, 32'h0000_0080);

      // Half store merges into an existing word.
      core_op("wr_w0", 1'b1, 1'b0, 2'd2, 32'h0, 32'hAABB_CCDD, 1'b0, 1'b1);
      core_op("wr_h2", 1'b1, 1'b0, 2'd1, 32'h2, 32'h0000_BEEF, 1'b0, 1'b1);
      core_op("rd_w0b", 1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 1'b0, 1'b1);
      check_eq("half_merge", read_data, 32'hBEEF_CCDD);

      // Misaligned word read.
      core_op("rd_w2", 1'b0, 1'b1, 2'd2, 32'h2, 32'h0, 1'b0, 1'b1);
      if (TrapEn) begin
         check_eq("mis_trap_pulse", {31'b0, misaligned}, 32'h1);
         core_op("after_trap", 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
         check_eq("mis_trap_clear", {31'b0, misaligned}, 32'h0);
      end else begin
         check_eq("mis_forced", read_data, 32'hBEEF_CCDD);
      end

      // Stalled write is dropped; write+read performs only the write.
      core_op("stall_wr", 1'b1, 1'b0, 2'd2, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
      core_op("rd_stall", 1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 1'b0, 1'b1);
      check_eq("stall_nochange", read_data, 32'hBEEF_CCDD);
      core_op("wr_rd", 1'b1, 1'b1, 2'd2, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
      check_eq("wr_rd_novalid", {31'b0, read_valid}, 32'h0);
      core_op("rd_wr_rd", 1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 1'b0, 1'b1);
      check_eq("wr_rd_written", read_data, 32'h0BAD_F00D);

      // Top-of-array accesses with high address bits set must alias modulo depth.
      core_op("wr_top", 1'b1, 1'b0, 2'd2, 32'hFFFF_FFFC, 32'hCAFE_1234, 1'b0, 1'b1);
      core_op("rd_top", 1'b0, 1'b1, 2'd1, 32'h0000_03FE, 32'h0, 1'b1, 1'b1);
      check_eq("top_half", read_data, 32'h0000_CAFE);

      // Randomized traffic, biased to a small window so reads hit written data.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            r_addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
         end else begin
            r_addr = $urandom;
         end
         core_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), r_addr, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the byte-address width; depth is 2**ADDR_W bytes.
REQ-002 SHALL have parameter LOAD_W, default 8, giving the loader byte-stream width; only 8 is legal.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port load, input, 1, loader strobe; one byte is stored per asserted cycle.
REQ-006 SHALL have port store, input, 8, loader byte.
REQ-007 SHALL have port ready, input, 1, core-ready; when low, core accesses are stalled.
REQ-008 SHALL have port mem_write, input, 1, core write request.
REQ-009 SHALL have port mem_read, input, 1, core read request.
REQ-010 SHALL have port size, input, 2, access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-011 SHALL have port unsigned_ld, input, 1, selects zero-extension of byte/half loads; when low, loads sign-extend.
REQ-012 SHALL have port address, input, 32, byte address; only bits [ADDR_W-1:0] are used, so accesses wrap modulo depth.
REQ-013 SHALL have port write_data, input, 32, store data, taken from the low-order bytes for byte and half stores.
REQ-014 SHALL have port read_data, output, 32, registered load result.
REQ-015 SHALL have port read_valid, output, 1, one-cycle pulse indicating read_data has been updated.
REQ-016 SHALL have port load_full, output, 1, sticky flag set when the loader has filled every byte.
REQ-017 SHALL have port misaligned, output, 1, one-cycle pulse flagging a misaligned core access.

Function
REQ-018 SHALL use little-endian byte order: byte N of a word resides at address+N.
REQ-019 SHALL apply per-cycle priority in this order: load, then ~ready (stall, no access), then mem_write, then mem_read.
REQ-020 SHALL, on load with load_full low, write store to mem[load_ptr] and increment load_ptr.
REQ-021 SHALL set load_full when load_ptr wraps past 2**ADDR_W-1, and SHALL ignore further load strobes while load_full is high.
REQ-022 SHALL, on a write, update only the addressed bytes: 1 byte, 2 bytes, or 4 bytes according to size.
REQ-023 SHALL, on a read, present the extended result on read_data one cycle later with read_valid high for exactly that cycle.
REQ-024 SHALL hold read_data unchanged when no read completes.
REQ-025 SHALL, when mem_write and mem_read are both high, perform the write only, with no read_valid pulse.
REQ-026 SHALL treat a half access with address[0]=1, or a word access with address[1:0]!=0, as misaligned.
REQ-027 SHALL, for an access whose bytes extend past the top address, wrap the extra bytes to address 0.

Reset
REQ-028 SHALL, with rst_n low at a clock edge, clear read_data, read_valid, misaligned, load_full and load_ptr to 0.
REQ-029 SHALL NOT clear memory contents on reset.
REQ-030 SHALL give reset priority over load, so that a reset mid-load restarts loading at address 0.

Configuration
REQ-031 SHALL, with DMEM_MISALIGN_TRAP_EN defined, suppress a misaligned access (no memory change, no read_valid) and pulse misaligned one cycle later.
REQ-032 SHALL, without DMEM_MISALIGN_TRAP_EN, force the misaligned address down to the size boundary, perform the access, and tie misaligned to 0.

Structure
REQ-033 SHALL place the size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD) and the DEPTH constant function in the shared package dmem_pkg.
REQ-034 SHALL implement the loader pointer and load_full flag in the sub-module dmem_loader; the byte array and access logic remain in the top level.

Verification
REQ-035 SHALL check that 4 load strobes with bytes 0x11, 0x22, 0x33, 0x44, followed by a word read at address 0, give read_data=0x44332211 and a read_valid pulse.
REQ-036 SHALL check that a byte store of 0x80 at address 5, read back as a byte, gives 0xFFFFFF80 signed and 0x00000080 with unsigned_ld=1.
REQ-037 SHALL check that a half store of 0xBEEF at address 2 over word 0xAABBCCDD at address 0 gives a word read of 0xBEEFCCDD.
REQ-038 SHALL check that a word read at address 2 gives a misaligned pulse and no read_valid with DMEM_MISALIGN_TRAP_EN, and returns the data of address 0 without it.
REQ-039 SHALL check that 1024 load strobes (ADDR_W=10) set load_full and that a 1025th strobe leaves mem[0] unchanged; a subsequent reset clears load_full.
REQ-040 SHALL check that ready=0 with mem_write high leaves memory unchanged, and that simultaneous mem_write and mem_read produce no read_valid.
